// File: rtl/up_counter_monitor.sv
// Receive-side checker for a free-running up-count pad bus, with its own pad ring.
// Optional build macro MONITOR_ZERO_RESYNC_EN: a mismatching 0 while tracking is taken as a peer counter restart.

module pc3d01 (
    input  logic pad,
    output logic cin
);
    assign cin = pad;
endmodule

module pc3c01 (
    input  logic cclk,
    output logic cp
);
    assign cp = cclk;
endmodule

module pc3o05 (
    input  logic i,
    output logic pad
);
    assign pad = i;
endmodule

module up_counter_monitor #(
    parameter int WIDTH     = 4,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk_pad,
    input  logic                 reset_n_pad,
    input  logic [WIDTH-1:0]     count_pad,
    output logic                 locked_pad,
    output logic                 wrap_pad,
    output logic                 err_pad,
    output logic [ERR_CNT_W-1:0] err_cnt_pad
);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] LOCK_VAL = GOOD_W'(LOCK_CNT);
    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    localparam logic [1:0] ST_ACQ   = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;

    logic                 clk_buf;
    logic                 clk;
    logic                 rst_n;
    logic [WIDTH-1:0]     count;

    logic [WIDTH-1:0]     samp_q;
    logic                 samp_vld_q;
    logic [WIDTH-1:0]     ref_q;
    logic [GOOD_W-1:0]    good_q;
    logic [1:0]           state_q;
    logic                 wrap_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic                 match;
    logic                 zero_resync;

    // Input pad ring
    pc3d01 u_clk_pad (.pad(clk_pad), .cin(clk_buf));
    pc3c01 u_clk_drv (.cclk(clk_buf), .cp(clk));
    pc3d01 u_rst_pad (.pad(reset_n_pad), .cin(rst_n));

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_count_pad
            pc3d01 u_pad (.pad(count_pad[gi]), .cin(count[gi]));
        end
    endgenerate

    assign match = (samp_q == ref_q + CNT_ONE);

`ifdef MONITOR_ZERO_RESYNC_EN
    assign zero_resync = (samp_q == '0);
`else
    assign zero_resync = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q     <= '0;
            samp_vld_q <= 1'b0;
            ref_q      <= '0;
            good_q     <= '0;
            state_q    <= ST_ACQ;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            samp_q     <= count;
            samp_vld_q <= 1'b1;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            // samp_q only carries a real capture from the second edge after release
            if (samp_vld_q) begin
                ref_q <= samp_q;
                case (state_q)
                    ST_ACQ: begin
                        good_q  <= '0;
                        state_q <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (!match) begin
                            good_q <= '0;
                        end else if (good_q + GOOD_ONE == LOCK_VAL) begin
                            good_q  <= '0;
                            state_q <= ST_TRACK;
                        end else begin
                            good_q <= good_q + GOOD_ONE;
                        end
                    end
                    ST_TRACK: begin
                        if (match) begin
                            wrap_q <= (samp_q == '0);
                        end else if (!zero_resync) begin
                            err_q   <= 1'b1;
                            good_q  <= '0;
                            state_q <= ST_SYNC;
                            if (err_cnt_q != '1) begin
                                err_cnt_q <= err_cnt_q + ERR_ONE;
                            end
                        end
                    end
                    default: begin
                        good_q  <= '0;
                        state_q <= ST_ACQ;
                    end
                endcase
            end
        end
    end

    // Output pad ring
    pc3o05 u_locked_pad (.i(state_q == ST_TRACK), .pad(locked_pad));
    pc3o05 u_wrap_pad   (.i(wrap_q), .pad(wrap_pad));
    pc3o05 u_err_pad    (.i(err_q), .pad(err_pad));

    generate
        for (genvar gi = 0; gi < ERR_CNT_W; gi++) begin : g_err_cnt_pad
            pc3o05 u_pad (.i(err_cnt_q[gi]), .pad(err_cnt_pad[gi]));
        end
    endgenerate

endmodule
